// File: rtl/shifter_pkg.sv
// Shared op encoding and helpers for the pipelined log shifter.
// SHIFTER_ROTATE_EN selects whether op 11 (ROR) is a supported operation.
package shifter_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_SLL = 2'b00;
    localparam op_t OP_SRL = 2'b01;
    localparam op_t OP_SRA = 2'b10;
    localparam op_t OP_ROR = 2'b11;

`ifdef SHIFTER_ROTATE_EN
    localparam bit ROTATE_EN = 1'b1;
`else
    localparam bit ROTATE_EN = 1'b0;
`endif

    function automatic logic op_supported(input op_t op);
        return (op != OP_ROR) || ROTATE_EN;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational log-shifter level: shifts by AMT when en is set, otherwise passes src through.
// Rotate support is only built when SHIFTER_ROTATE_EN is defined; otherwise op 11 passes through.
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int AMT   = 1
) (
    input  logic [WIDTH-1:0] src,
    input  logic             en,
    input  op_t              op,
    output logic [WIDTH-1:0] res
);

    // SRA fill uses the current MSB: earlier arithmetic levels never change the sign bit.
    always_comb begin
        res = src;
        if (en) begin
            case (op)
                OP_SLL:  res = src << AMT;
                OP_SRL:  res = src >> AMT;
                OP_SRA:  res = {{AMT{src[WIDTH-1]}}, src[WIDTH-1:AMT]};
`ifdef SHIFTER_ROTATE_EN
                OP_ROR:  res = {src[AMT-1:0], src[WIDTH-1:AMT]};
`endif
                default: res = src;
            endcase
        end
    end

endmodule

// File: rtl/shifter_pipe.sv
// Two-stage pipelined shifter (SLL/SRL/SRA, ROR with SHIFTER_ROTATE_EN); latency 2 cycles.
// Valid/ready on both sides; S2 holds on out_ready=0 and S1 holds behind it, one accept per cycle otherwise.
module shifter_pipe
    import shifter_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_err
);

    // Levels SHW-1..LO run before S1, levels LO-1..0 run between S1 and S2.
    localparam int LO = SHW / 2;

    logic             s1_vld;
    logic [WIDTH-1:0] s1_data;
    logic [LO-1:0]    s1_shamt;
    op_t              s1_op;

    logic             s2_vld;
    logic [WIDTH-1:0] s2_data;
    logic             s2_err;

    logic             stall;
    logic [WIDTH-1:0] fin_data;
    logic             fin_err;

    for (genvar k = LO; k < SHW; k++) begin : g_hi
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] res;
        if (k == SHW - 1) begin : g_src
            assign src = in_data;
        end else begin : g_src
            assign src = g_hi[k+1].res;
        end
        shift_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << k)
        ) u_stage (
            .src (src),
            .en  (in_shamt[k]),
            .op  (in_op),
            .res (res)
        );
    end

    for (genvar k = 0; k < LO; k++) begin : g_lo
        logic [WIDTH-1:0] src;
        logic [WIDTH-1:0] res;
        if (k == LO - 1) begin : g_src
            assign src = s1_data;
        end else begin : g_src
            assign src = g_lo[k+1].res;
        end
        shift_stage #(
            .WIDTH (WIDTH),
            .AMT   (1 << k)
        ) u_stage (
            .src (src),
            .en  (s1_shamt[k]),
            .op  (s1_op),
            .res (res)
        );
    end

    assign fin_err  = !op_supported(s1_op);
    assign fin_data = fin_err ? '0 : g_lo[0].res;

    assign stall     = s2_vld && !out_ready;
    assign in_ready  = !(s1_vld && stall);
    assign out_valid = s2_vld;
    assign out_data  = s2_data;
    assign out_err   = s2_err;

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s2_data <= '0;
            s2_err  <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_vld <= in_valid;
            end
            if (!stall) begin
                s2_vld <= s1_vld;
                if (s1_vld) begin
                    s2_data <= fin_data;
                    s2_err  <= fin_err;
                end
            end
        end
    end

    // Payload registers only load on accept, so they need no reset.
    always_ff @(posedge clock) begin
        if (in_ready && in_valid) begin
            s1_data  <= g_hi[LO].res;
            s1_shamt <= in_shamt[LO-1:0];
            s1_op    <= in_op;
        end
    end

endmodule
